// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and constants for the packet-aware round-robin stream arbiter.
package stream_rr_arbiter_pkg;

    localparam int unsigned PKT_CNT_WD  = 16;
    localparam int unsigned DEF_DATA_WD = 32;
    localparam int unsigned DEF_N_REQ   = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned IDX_WD = 2
) (
    input  logic [N_REQ-1:0]  req,
    input  logic [IDX_WD-1:0] rr_ptr,
    output logic [IDX_WD-1:0] grant_idx,
    output logic              any_req
);

    localparam logic [IDX_WD:0] N_REQ_W = (IDX_WD+1)'(N_REQ);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_WD-1:0]  enc;
    logic [IDX_WD:0]    sum;

    // Rotate so rr_ptr lands at bit 0, pick lowest set bit, then rotate the index back.
    always_comb begin
        req_dbl   = {req, req};
        req_rot   = N_REQ'(req_dbl >> rr_ptr);
        enc       = '0;
        any_req   = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req_rot[i] && !any_req) begin
                enc     = IDX_WD'(i);
                any_req = 1'b1;
            end
        end
        sum = {1'b0, enc} + {1'b0, rr_ptr};
        if (sum >= N_REQ_W) begin
            sum = sum - N_REQ_W;
        end
        grant_idx = any_req ? sum[IDX_WD-1:0] : rr_ptr;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-way stream arbiter that holds the grant for a whole packet and rotates priority per packet.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WD = DEF_DATA_WD,
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned IDX_WD  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         valid_pre_i,
    input  logic [N_REQ*DATA_WD-1:0] data_pre_i,
    input  logic [N_REQ-1:0]         last_pre_i,
    output logic [N_REQ-1:0]         ready_pre_o,
    output logic                     valid_post_o,
    output logic [DATA_WD-1:0]       data_post_o,
    output logic                     last_post_o,
    input  logic                     ready_post_i,
    output logic [IDX_WD-1:0]        grant_o,
    output logic                     locked_o,
    output logic [PKT_CNT_WD-1:0]    pkt_cnt_o
);

    localparam logic [IDX_WD-1:0] LAST_IDX = IDX_WD'(N_REQ - 1);

    state_e                  state_q, state_d;
    logic [IDX_WD-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_WD-1:0]       lock_idx_q, lock_idx_d;
    logic [PKT_CNT_WD-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic [IDX_WD-1:0]       pick_idx;
    logic                    any_req;
    logic [IDX_WD-1:0]       grant;
    logic                    sel_valid;
    logic                    fire;

    rr_pick #(
        .N_REQ  (N_REQ),
        .IDX_WD (IDX_WD)
    ) u_rr_pick (
        .req       (valid_pre_i),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

    // Zero-latency output mux; the lock pins the grant for the rest of a packet.
    always_comb begin
        grant       = (state_q == ST_LOCKED) ? lock_idx_q : pick_idx;
        sel_valid   = 1'b0;
        data_post_o = '0;
        last_post_o = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (grant == IDX_WD'(k)) begin
                sel_valid   = valid_pre_i[k];
                data_post_o = data_pre_i[k*DATA_WD +: DATA_WD];
                last_post_o = last_pre_i[k];
            end
        end
        valid_post_o = (state_q == ST_LOCKED) ? sel_valid : any_req;
        fire         = valid_post_o && ready_post_i;
        for (int k = 0; k < int'(N_REQ); k++) begin
            ready_pre_o[k] = (grant == IDX_WD'(k)) && valid_post_o && ready_post_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        pkt_cnt_d  = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fire && !last_post_o) begin
                    state_d    = ST_LOCKED;
                    lock_idx_d = grant;
                end
            end
            ST_LOCKED: begin
                if (fire && last_post_o) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Priority moves past whoever just finished a packet.
        if (fire && last_post_o) begin
            rr_ptr_d  = (grant == LAST_IDX) ? '0 : grant + IDX_WD'(1);
            pkt_cnt_d = pkt_cnt_q + PKT_CNT_WD'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign grant_o   = grant;
    assign locked_o  = (state_q == ST_LOCKED);
    assign pkt_cnt_o = pkt_cnt_q;

endmodule
